// File: rtl/boss_pathfinder_if.sv
// boss_pathfinder_if: request/result handshake and map-query signals
// between game-play logic, the tile map and the pathfinder.
interface boss_pathfinder_if #(
    parameter int XW = 6,
    parameter int YW = 6
);
    logic          start;
    logic [XW-1:0] player_tx;
    logic [YW-1:0] player_ty;
    logic [XW-1:0] boss_tx;
    logic [YW-1:0] boss_ty;
    logic [XW-1:0] map_rd_x;
    logic [YW-1:0] map_rd_y;
    logic          map_wall;
    logic          busy;
    logic          done;
    logic [2:0]    dir;
    logic          reachable;
    logic          overflow;

    modport master (
        output start, player_tx, player_ty,
        output boss_tx, boss_ty, map_wall,
        input  map_rd_x, map_rd_y, busy, done,
        input  dir, reachable, overflow
    );

    modport slave (
        input  start, player_tx, player_ty,
        input  boss_tx, boss_ty, map_wall,
        output map_rd_x, map_rd_y, busy, done,
        output dir, reachable, overflow
    );
endinterface

// File: rtl/boss_pathfinder.sv
// boss_pathfinder: breadth-first search from the player tile; the boss
// steps back toward whichever node first discovers the boss tile.
module boss_pathfinder #(
    parameter int MAP_W  = 40,
    parameter int MAP_H  = 40,
    parameter int XW     = 6,
    parameter int YW     = 6,
    parameter int QDEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    boss_pathfinder_if.slave bus
);
    localparam int QW = $clog2(QDEPTH);
    localparam int VW = $clog2(MAP_W * MAP_H);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SEED, S_POP, S_EXP, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [XW-1:0] px, bx, nx, mx, push_x;
    logic [YW-1:0] py, by, ny, my, push_y;
    logic [YW-1:0] clr_row;
    logic [1:0]    k;
    logic [3:0]    k_oh;
    logic [QW:0]   rd_ptr, wr_ptr;

    logic [MAP_W*MAP_H-1:0] visited;
    logic [XW+YW-1:0]       q_mem [QDEPTH];

    logic [2:0] dir_q, res_dir;
    logic       reach_q, ovf_q;
    logic       res_reach, res_ovf, push;
    logic       m_ok, m_vis, m_boss;
    logic       q_empty, q_full;

    function automatic logic [VW-1:0] vidx(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        return VW'(y) * VW'(MAP_W) + VW'(x);
    endfunction

    // Neighbour of the current node in UP, LEFT, DOWN, RIGHT order
    always_comb begin
        k_oh = 4'b0001 << k;
        mx   = nx;
        my   = ny;
        m_ok = 1'b0;
        unique case (1'b1)
            k_oh[0]: begin
                my   = ny - 1'b1;
                m_ok = (ny != '0);
            end
            k_oh[1]: begin
                mx   = nx - 1'b1;
                m_ok = (nx != '0);
            end
            k_oh[2]: begin
                my   = ny + 1'b1;
                m_ok = (ny != YW'(MAP_H - 1));
            end
            k_oh[3]: begin
                mx   = nx + 1'b1;
                m_ok = (nx != XW'(MAP_W - 1));
            end
        endcase
    end

    assign m_vis   = visited[vidx(mx, my)];
    assign m_boss  = (mx == bx) && (my == by);
    assign q_empty = (rd_ptr == wr_ptr);
    assign q_full  = (rd_ptr[QW] != wr_ptr[QW]) &&
                     (rd_ptr[QW-1:0] == wr_ptr[QW-1:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        res_dir   = 3'd0;
        res_reach = 1'b0;
        res_ovf   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.player_tx == bus.boss_tx &&
                        bus.player_ty == bus.boss_ty) begin
                        state_nx  = S_DONE;
                        res_reach = 1'b1;
                    end else begin
                        state_nx = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_row == YW'(MAP_H - 1))
                    state_nx = S_SEED;
            end
            S_SEED: begin
                if (bus.map_wall) begin
                    state_nx = S_DONE;
                end else begin
                    push     = 1'b1;
                    state_nx = S_POP;
                end
            end
            S_POP: begin
                state_nx = q_empty ? S_DONE : S_EXP;
            end
            S_EXP: begin
                if (k == 2'd3)
                    state_nx = S_POP;
                if (m_ok && !bus.map_wall && !m_vis) begin
                    if (m_boss) begin
                        state_nx  = S_DONE;
                        res_reach = 1'b1;
                        // reverse of the search step k
                        res_dir   = 3'd1 + {1'b0, k + 2'd2};
                    end else if (q_full) begin
                        state_nx = S_DONE;
                        res_ovf  = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.map_rd_x = '0;
        bus.map_rd_y = '0;
        case (state)
            S_CLEAR, S_POP: bus.busy = 1'b1;
            S_SEED: begin
                bus.busy     = 1'b1;
                bus.map_rd_x = px;
                bus.map_rd_y = py;
            end
            S_EXP: begin
                bus.busy = 1'b1;
                if (m_ok) begin
                    bus.map_rd_x = mx;
                    bus.map_rd_y = my;
                end
            end
            default: ;
        endcase
    end

    assign bus.done      = (state == S_DONE);
    assign bus.dir       = dir_q;
    assign bus.reachable = reach_q;
    assign bus.overflow  = ovf_q;

    assign push_x = (state == S_SEED) ? px : mx;
    assign push_y = (state == S_SEED) ? py : my;

    always_ff @(posedge clk) begin
        if (rst) begin
            px      <= '0;
            py      <= '0;
            bx      <= '0;
            by      <= '0;
            nx      <= '0;
            ny      <= '0;
            k       <= '0;
            clr_row <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            dir_q   <= 3'd0;
            reach_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                px      <= bus.player_tx;
                py      <= bus.player_ty;
                bx      <= bus.boss_tx;
                by      <= bus.boss_ty;
                clr_row <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end
            if (state == S_CLEAR)
                clr_row <= clr_row + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (state == S_POP && !q_empty) begin
                {ny, nx} <= q_mem[rd_ptr[QW-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
                k        <= '0;
            end
            if (state == S_EXP)
                k <= k + 1'b1;
            if (state != S_DONE && state_nx == S_DONE) begin
                dir_q   <= res_dir;
                reach_q <= res_reach;
                ovf_q   <= res_ovf;
            end
        end
    end

    // Contents are rebuilt by every search, so no reset is needed
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            visited[vidx(XW'(0), clr_row) +: MAP_W] <= '0;
        if (push) begin
            q_mem[wr_ptr[QW-1:0]]     <= {push_y, push_x};
            visited[vidx(push_x, push_y)] <= 1'b1;
        end
    end
endmodule
